mips_multicycle_ctrl: RTL and testbench

//  Instruction-decode end of the MIPS instruction format: latches the fetched word into an IR, splits it into R/I/J fields
//  and runs the multi-cycle control FSM that sequences fetch, decode, execute, memory and writeback.

---
 rtl/mips_multicycle_ctrl_if.sv | 52 +++++
 rtl/mips_multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose : bundle between the multi-cycle MIPS controller and the memory/datapath it drives.
// Latency : n/a (wires only); master = controller, slave = datapath/memory side.
// Ports   : mem_rdata/mem_ready/alu_zero flow into the controller; IR fields, strobes, selects and state flow out.
interface mips_multicycle_ctrl_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   mem_ready;
  logic                   alu_zero;

  logic [INSTR_WIDTH-1:0] ir_q;
  logic [4:0]             rs_o;
  logic [4:0]             rt_o;
  logic [4:0]             rd_o;
  logic [4:0]             shamt_o;
  logic [DATA_WIDTH-1:0]  imm_ext;
  logic [25:0]            jump_o;

  logic                   ir_write;
  logic                   pc_write;
  logic                   pc_write_cond;
  logic                   pc_en;
  logic [1:0]             pc_src;
  logic                   i_or_d;
  logic                   mem_read;
  logic                   mem_write;
  logic                   reg_write;
  logic                   reg_dst;
  logic                   mem_to_reg;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [2:0]             alu_op;
  logic                   illegal_instr;
  logic [3:0]             state_o;

  modport master (
    input  mem_rdata, mem_ready, alu_zero,
    output ir_q, rs_o, rt_o, rd_o, shamt_o, imm_ext, jump_o,
           ir_write, pc_write, pc_write_cond, pc_en, pc_src, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, illegal_instr, state_o
  );

  modport slave (
    output mem_rdata, mem_ready, alu_zero,
    input  ir_q, rs_o, rt_o, rd_o, shamt_o, imm_ext, jump_o,
           ir_write, pc_write, pc_write_cond, pc_en, pc_src, i_or_d,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, illegal_instr, state_o
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Purpose : MIPS multi-cycle control - IR latch, R/I/J field split and the fetch/decode/execute/mem/writeback FSM.
// Latency : FETCH to FETCH at zero-wait memory: R 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles.
// Backpr. : FETCH, MEMRD and MEMWR hold their request until mem_ready; synchronous active-high rst abandons any access.
// Ports   : clk, rst plain; everything else through mips_multicycle_ctrl_if.master (memory in, datapath strobes out).
module mips_multicycle_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [3:0]             state, state_nxt;
  logic [INSTR_WIDTH-1:0] ir;
  logic [5:0]             op, funct;

  logic       ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_instr;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;

  assign op    = ir[31:26];
  assign funct = ir[5:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_write) ir <= bus.mem_rdata;
    end
  end

  // Outputs decode from state only, except the mem_ready-gated FETCH strobes and
  // the op/funct legality pulses. Everything stays at its idle value under rst.
  always_comb begin
    state_nxt     = state;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    illegal_instr = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;          // PC + 4
          if (bus.mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;          // speculative branch target into ALUOut
          case (op)
            6'b100011, 6'b101011: state_nxt = S_MEMADR;
            6'b000000:            state_nxt = S_EXECUTE;
            6'b000100:            state_nxt = S_BRANCH;
            6'b001000:            state_nxt = S_ADDIEXEC;
            6'b000010:            state_nxt = S_JUMP;
            default: begin
              illegal_instr = 1'b1;
              state_nxt     = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_nxt = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
          if (bus.mem_ready) state_nxt = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_MEMWR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          if (bus.mem_ready) state_nxt = S_FETCH;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          state_nxt = S_ALUWB;
          case (funct)
            6'b100000: alu_op = ALU_ADD;
            6'b100010: alu_op = ALU_SUB;
            6'b100100: alu_op = ALU_AND;
            6'b100101: alu_op = ALU_OR;
            6'b101010: alu_op = ALU_SLT;
            default: begin
              illegal_instr = 1'b1;
              state_nxt     = S_FETCH;
            end
          endcase
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_nxt = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_src        = 2'b01;
          pc_write_cond = 1'b1;
          state_nxt     = S_FETCH;
        end
        S_ADDIEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_nxt = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
          state_nxt = S_FETCH;
        end
        S_JUMP: begin
          pc_src    = 2'b10;
          pc_write  = 1'b1;
          state_nxt = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  assign bus.ir_q          = ir;
  assign bus.rs_o          = ir[25:21];
  assign bus.rt_o          = ir[20:16];
  assign bus.rd_o          = ir[15:11];
  assign bus.shamt_o       = ir[10:6];
  assign bus.imm_ext       = {{(DATA_WIDTH-16){ir[15]}}, ir[15:0]};
  assign bus.jump_o        = ir[25:0];
  assign bus.ir_write      = ir_write;
  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.pc_en         = pc_write | (pc_write_cond & bus.alu_zero);
  assign bus.pc_src        = pc_src;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.reg_write     = reg_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.illegal_instr = illegal_instr;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose : self-checking bench for mips_multicycle_ctrl; per-cycle expected controls queued as stimulus is driven.
// Latency : one vector per clock, inputs driven at negedge, outputs sampled 1 time unit later.
// Ports   : drives clk/rst and the slave side of mips_multicycle_ctrl_if.
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  // {state, ir_write, pc_write, pc_write_cond, pc_en, pc_src, i_or_d, mem_read, mem_write,
  //  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_instr}
  typedef logic [22:0] vec_t;
  typedef struct packed {
    vec_t        v;
    logic [31:0] ir;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();
  mips_multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  sb_t         sb[$];
  logic [31:0] cur_ir = 32'h0;
  int          n_vec  = 0;
  int          n_err  = 0;

  // Expected controls for a given state, written from the control table.
  function automatic vec_t model(logic [3:0] st, logic [31:0] ir, logic rdy, logic zero, logic r);
    logic irw = 0, pcw = 0, pcwc = 0, pcen = 0, iod = 0, mr = 0, mw = 0;
    logic rw = 0, rdst = 0, m2r = 0, sa = 0, ill = 0;
    logic [1:0] psrc = 0, sb_sel = 0;
    logic [2:0] aop = 0;
    if (!r) begin
      case (st)
        S_FETCH:    begin mr = 1; sb_sel = 2'b01; irw = rdy; pcw = rdy; pcen = rdy; end
        S_DECODE:   begin
          sb_sel = 2'b11;
          if (!(ir[31:26] inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02})) ill = 1;
        end
        S_MEMADR:   begin sa = 1; sb_sel = 2'b10; end
        S_MEMRD:    begin iod = 1; mr = 1; end
        S_MEMWB:    begin rw = 1; m2r = 1; end
        S_MEMWR:    begin iod = 1; mw = 1; end
        S_EXECUTE:  begin
          sa = 1;
          case (ir[5:0])
            6'h20: aop = 3'b000;
            6'h22: aop = 3'b001;
            6'h24: aop = 3'b010;
            6'h25: aop = 3'b011;
            6'h2A: aop = 3'b100;
            default: ill = 1;
          endcase
        end
        S_ALUWB:    begin rw = 1; rdst = 1; end
        S_BRANCH:   begin sa = 1; aop = 3'b001; psrc = 2'b01; pcwc = 1; pcen = zero; end
        S_ADDIEXEC: begin sa = 1; sb_sel = 2'b10; end
        S_ADDIWB:   begin rw = 1; end
        S_JUMP:     begin psrc = 2'b10; pcw = 1; pcen = 1; end
        default:    ;
      endcase
    end
    return {st, irw, pcw, pcwc, pcen, psrc, iod, mr, mw, rw, rdst, m2r, sa, sb_sel, aop, ill};
  endfunction

  function automatic vec_t obs();
    return {bus.state_o, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.pc_en, bus.pc_src,
            bus.i_or_d, bus.mem_read, bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal_instr};
  endfunction

  // Drive one cycle of stimulus and queue the expected outputs for it.
  task automatic drive(logic [3:0] st, logic [31:0] rdata, logic rdy, logic zero, logic r);
    @(negedge clk);
    rst           = r;
    bus.mem_rdata = rdata;
    bus.mem_ready = rdy;
    bus.alu_zero  = zero;
    sb.push_back('{v: model(st, cur_ir, rdy, zero, r), ir: cur_ir});
    if (r) cur_ir = 32'h0;
    else if (st == S_FETCH && rdy) cur_ir = rdata;
    #1;
  endtask

  task automatic test_reset();
    sb_t  e;
    vec_t o;
    logic [3:0] sts [3];
    logic       rdy [3];
    logic       rr  [3];
    sts = '{S_FETCH, S_FETCH, S_FETCH};
    rdy = '{1'b1, 1'b1, 1'b0};
    rr  = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(sts[i], 32'hDEADBEEF, rdy[i], 1'b0, rr[i]);
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e.v || bus.ir_q !== e.ir) begin
        n_err++;
        $display("FAIL reset[%0d]: got ctl=%h ir=%h, want ctl=%h ir=%h", i, o, bus.ir_q, e.v, e.ir);
      end
    end
  endtask

  task automatic test_r_type();
    sb_t  e;
    vec_t o;
    logic [3:0] sts [4];
    sts = '{S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB};
    for (int i = 0; i < 4; i++) begin
      drive(sts[i], 32'h00221820, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e.v || bus.ir_q !== e.ir) begin
        n_err++;
        $display("FAIL r_type[%0d]: got ctl=%h ir=%h, want ctl=%h ir=%h", i, o, bus.ir_q, e.v, e.ir);
      end
    end
    n_vec++;
    if (bus.rd_o !== 5'd3 || bus.rs_o !== 5'd1 || bus.rt_o !== 5'd2) begin
      n_err++;
      $display("FAIL r_fields: got rs=%0d rt=%0d rd=%0d, want 1 2 3", bus.rs_o, bus.rt_o, bus.rd_o);
    end
  endtask

  task automatic test_lw_wait();
    sb_t  e;
    vec_t o;
    logic [3:0] sts [7];
    logic       rdy [7];
    sts = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(sts[i], (i == 0) ? 32'h8C220004 : 32'h12345678, rdy[i], 1'b0, 1'b0);
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e.v || bus.ir_q !== e.ir) begin
        n_err++;
        $display("FAIL lw[%0d]: got ctl=%h ir=%h, want ctl=%h ir=%h", i, o, bus.ir_q, e.v, e.ir);
      end
    end
    n_vec++;
    if (bus.imm_ext !== 32'h00000004) begin
      n_err++;
      $display("FAIL lw_imm: got %h, want 00000004", bus.imm_ext);
    end
  endtask

  task automatic test_beq();
    sb_t  e;
    vec_t o;
    logic [3:0] sts [6];
    logic       zr  [6];
    sts = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_BRANCH};
    zr  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(sts[i], 32'h1022FFFF, 1'b1, zr[i], 1'b0);
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e.v || bus.ir_q !== e.ir) begin
        n_err++;
        $display("FAIL beq[%0d]: got ctl=%h ir=%h, want ctl=%h ir=%h", i, o, bus.ir_q, e.v, e.ir);
      end
    end
    n_vec++;
    if (bus.imm_ext !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL beq_imm: got %h, want ffffffff", bus.imm_ext);
    end
  endtask

  task automatic test_illegal();
    sb_t  e;
    vec_t o;
    logic [3:0]  sts [5];
    logic [31:0] dat [5];
    sts = '{S_FETCH, S_DECODE, S_FETCH, S_DECODE, S_EXECUTE};
    dat = '{32'hFC000000, 32'h0, 32'h0000003F, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(sts[i], dat[i], 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e.v || bus.ir_q !== e.ir) begin
        n_err++;
        $display("FAIL illegal[%0d]: got ctl=%h ir=%h, want ctl=%h ir=%h", i, o, bus.ir_q, e.v, e.ir);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t  e;
    vec_t o;
    logic [3:0]  sts [7];
    logic [31:0] dat [7];
    sts = '{S_FETCH, S_DECODE, S_ADDIEXEC, S_ADDIWB, S_FETCH, S_DECODE, S_JUMP};
    dat = '{32'h20220005, 32'h0, 32'h0, 32'h0, 32'h08000010, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      drive(sts[i], dat[i], 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e.v || bus.ir_q !== e.ir) begin
        n_err++;
        $display("FAIL b2b[%0d]: got ctl=%h ir=%h, want ctl=%h ir=%h", i, o, bus.ir_q, e.v, e.ir);
      end
    end
    n_vec++;
    if (bus.jump_o !== 26'h0000010) begin
      n_err++;
      $display("FAIL jump_field: got %h, want 0000010", bus.jump_o);
    end
  endtask

  task automatic test_sw_reset();
    sb_t  e;
    vec_t o;
    logic [3:0] sts [6];
    logic       rdy [6];
    logic       rr  [6];
    sts = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_FETCH};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    rr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(sts[i], (i == 0) ? 32'hAC220008 : 32'h0, rdy[i], 1'b0, rr[i]);
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e.v || bus.ir_q !== e.ir) begin
        n_err++;
        $display("FAIL sw_rst[%0d]: got ctl=%h ir=%h, want ctl=%h ir=%h", i, o, bus.ir_q, e.v, e.ir);
      end
    end
  endtask

  initial begin
    bus.mem_rdata = 32'h0;
    bus.mem_ready = 1'b1;
    bus.alu_zero  = 1'b0;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_sw_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
